poll_core: RTL and testbench

POLL_CORE -- requirements
Module: poll_core

---
 rtl/poll_core_pkg.sv | 38 +++
 rtl/poll_core_busy_handshake.sv | 76 +++++++
 rtl/poll_core.sv | 160 ++++++++++++++++
 tb/tb_poll_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/poll_core_pkg.sv
// Shared types and constants for the sensor polling core.
// Holds FSM encoding, frame header nibble and threshold helpers.
package poll_core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I2C_REQ,
    I2C_WAIT,
    CHECK,
    TX_HDR,
    TX_DATA,
    NEXT
  } state_t;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;
  localparam logic [7:0] DEF_TH_LO  = 8'd50;
  localparam logic [7:0] DEF_TH_HI  = 8'd120;
  localparam logic [7:0] DEF_HYST   = 8'd5;

  // Returns {set, clear}; 9-bit math so lo+hy and s+hy never wrap.
  function automatic logic [1:0] judge(
    input logic [7:0] s,
    input logic [7:0] lo,
    input logic [7:0] hi,
    input logic [7:0] hy
  );
    logic [8:0] s9, lo9, hi9, hy9;
    logic       set, clr;
    s9  = {1'b0, s};
    lo9 = {1'b0, lo};
    hi9 = {1'b0, hi};
    hy9 = {1'b0, hy};
    set = (s9 < lo9) || (s9 > hi9);
    clr = (s9 >= lo9 + hy9) && (s9 + hy9 <= hi9);
    return {set, clr};
  endfunction

endpackage

// File: rtl/poll_core_busy_handshake.sv
// Request/busy handshake with per-phase timeout.
// Phase 1 holds req until busy rises; phase 2 waits for busy to fall.
module busy_handshake #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic busy,
  output logic req,
  output logic done,
  output logic fail
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {H_REQ, H_WAIT} phase_t;

  phase_t        phase, phase_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          expired;

  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= H_REQ;
      cnt   <= '0;
    end else begin
      phase <= phase_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    req     = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
    phase_d = phase;
    cnt_d   = cnt;
    if (!en) begin
      phase_d = H_REQ;
      cnt_d   = '0;
    end else begin
      unique case (phase)
        H_REQ: begin
          req = 1'b1;
          if (busy) begin
            phase_d = H_WAIT;
            cnt_d   = '0;
          end else if (expired) begin
            fail  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        H_WAIT: begin
          if (!busy) begin
            done    = 1'b1;
            phase_d = H_REQ;
            cnt_d   = '0;
          end else if (expired) begin
            fail    = 1'b1;
            phase_d = H_REQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: phase_d = H_REQ;
      endcase
    end
  end

endmodule

// File: rtl/poll_core.sv
// Periodic I2C sensor poller with threshold alarms and UART reporting.
// Each round reads N_CH channels, judges them, and sends header+data.
module poll_core
  import poll_core_pkg::*;
#(
  parameter int         N_CH     = 4,
  parameter logic [7:0] I2C_DEV  = 8'h57,
  parameter logic [7:0] REG_BASE = 8'h05,
  parameter logic [7:0] TH_LO    = DEF_TH_LO,
  parameter logic [7:0] TH_HI    = DEF_TH_HI,
  parameter logic [7:0] HYST     = DEF_HYST,
  parameter int         PERIOD   = 1000,
  parameter int         TIMEOUT  = 255
) (
  input  logic            clk_core,
  input  logic            reset,
  output logic            ler_i2c,
  output logic [7:0]      add_I2C,
  output logic [7:0]      reg_I2C,
  input  logic            busy_I2C,
  input  logic [7:0]      din_I2C,
  output logic            send_UART,
  output logic [7:0]      tx_data_UART,
  input  logic            tx_busy_UART,
  input  logic            alarma,
  output logic            alarma_out,
  output logic [N_CH-1:0] ch_alarm,
  output logic [N_CH-1:0] ch_err
);

  localparam int PW = $clog2(PERIOD + 1);

  state_t          state, state_d;
  logic [3:0]      ch, ch_d;
  logic [PW-1:0]   pcnt;
  logic            wrap;
  logic [7:0]      sample;
  logic [N_CH-1:0] ch_mask, alarm_d;
  logic [1:0]      verdict;
  logic            mute, alarma_q;
  logic            i2c_en, i2c_req, i2c_done, i2c_fail;
  logic            uart_en, uart_req, uart_done, uart_fail;

  assign wrap    = (pcnt == PW'(PERIOD - 1));
  assign ch_mask = N_CH'(1) << ch;
  assign verdict = judge(sample, TH_LO, TH_HI, HYST);
  assign i2c_en  = (state == I2C_REQ) || (state == I2C_WAIT);
  assign uart_en = (state == TX_HDR) || (state == TX_DATA);

  busy_handshake #(.TIMEOUT(TIMEOUT)) u_i2c (
    .clk  (clk_core),
    .rst  (reset),
    .en   (i2c_en),
    .busy (busy_I2C),
    .req  (i2c_req),
    .done (i2c_done),
    .fail (i2c_fail)
  );

  busy_handshake #(.TIMEOUT(TIMEOUT)) u_uart (
    .clk  (clk_core),
    .rst  (reset),
    .en   (uart_en),
    .busy (tx_busy_UART),
    .req  (uart_req),
    .done (uart_done),
    .fail (uart_fail)
  );

  assign ler_i2c   = (state == I2C_REQ) && i2c_req;
  assign send_UART = uart_req;
  assign add_I2C   = i2c_en ? I2C_DEV : 8'h00;
  assign reg_I2C   = i2c_en ? REG_BASE + {4'h0, ch} : 8'h00;

  always_comb begin
    tx_data_UART = 8'h00;
    unique case (1'b1)
      state == TX_HDR:  tx_data_UART = {HDR_NIBBLE, ch};
      state == TX_DATA: tx_data_UART = sample;
      default:          tx_data_UART = 8'h00;
    endcase
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ch    <= '0;
      pcnt  <= '0;
    end else begin
      state <= state_d;
      ch    <= ch_d;
      pcnt  <= wrap ? '0 : pcnt + 1'b1;
    end
  end

  // Wraps outside IDLE are dropped: a late round is never queued.
  always_comb begin
    state_d = state;
    ch_d    = ch;
    unique case (state)
      IDLE: if (wrap) begin
        state_d = I2C_REQ;
        ch_d    = '0;
      end
      I2C_REQ:
        if (busy_I2C)      state_d = I2C_WAIT;
        else if (i2c_fail) state_d = CHECK;
      I2C_WAIT:
        if (i2c_done || i2c_fail) state_d = CHECK;
      CHECK: state_d = TX_HDR;
      TX_HDR:
        if (uart_fail)      state_d = NEXT;
        else if (uart_done) state_d = TX_DATA;
      TX_DATA:
        if (uart_done || uart_fail) state_d = NEXT;
      NEXT:
        if (ch == 4'(N_CH - 1)) begin
          state_d = IDLE;
        end else begin
          state_d = I2C_REQ;
          ch_d    = ch + 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alarm_d = ch_alarm;
    if (state == CHECK && (ch_err & ch_mask) == '0) begin
      if (verdict[1])      alarm_d = ch_alarm | ch_mask;
      else if (verdict[0]) alarm_d = ch_alarm & ~ch_mask;
    end
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      sample     <= 8'h00;
      ch_err     <= '0;
      ch_alarm   <= '0;
      mute       <= 1'b0;
      alarma_q   <= 1'b0;
      alarma_out <= 1'b0;
    end else begin
      if (state == I2C_WAIT && i2c_done) begin
        sample <= din_I2C;
        ch_err <= ch_err & ~ch_mask;
      end else if (i2c_fail) begin
        sample <= 8'hFF;
        ch_err <= ch_err | ch_mask;
      end
      ch_alarm <= alarm_d;
      alarma_q <= alarma;
      // A freshly raised alarm overrides a same-cycle mute press.
      if (|(alarm_d & ~ch_alarm))  mute <= 1'b0;
      else if (alarma && !alarma_q) mute <= 1'b1;
      alarma_out <= (|ch_alarm) & ~mute;
    end
  end

endmodule

// File: tb/tb_poll_core.sv
// Directed bench for poll_core: per-round vectors plus corner sequences.
// Peers answer busy one cycle after each request, driven on negedge.
module tb_poll_core;

  logic       clk_core = 1'b0;
  logic       reset = 1'b1;
  logic       ler_i2c, send_UART, alarma_out;
  logic [7:0] add_I2C, reg_I2C, tx_data_UART;
  logic       busy_I2C = 1'b0;
  logic [7:0] din_I2C = 8'h00;
  logic       tx_busy_UART = 1'b0;
  logic       alarma = 1'b0;
  logic [2:0] ch_alarm, ch_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] din_tab[3];
  logic [7:0] bytes[$];
  bit         i2c_stuck = 0;
  bit         uart_stuck = 0;
  bit         i2c_ph = 0;
  bit         u_ph = 0;
  logic       send_q = 1'b0;

  poll_core #(
    .N_CH(3), .PERIOD(100), .TIMEOUT(20)
  ) u_dut (
    .clk_core     (clk_core),
    .reset        (reset),
    .ler_i2c      (ler_i2c),
    .add_I2C      (add_I2C),
    .reg_I2C      (reg_I2C),
    .busy_I2C     (busy_I2C),
    .din_I2C      (din_I2C),
    .send_UART    (send_UART),
    .tx_data_UART (tx_data_UART),
    .tx_busy_UART (tx_busy_UART),
    .alarma       (alarma),
    .alarma_out   (alarma_out),
    .ch_alarm     (ch_alarm),
    .ch_err       (ch_err)
  );

  always #5 clk_core = ~clk_core;

  always @(negedge clk_core) begin
    int idx;
    if (i2c_ph) begin
      idx = int'(reg_I2C) - 5;
      din_I2C  = (idx >= 0 && idx < 3) ? din_tab[idx] : 8'h00;
      busy_I2C = 1'b0;
      i2c_ph   = 0;
    end else if (ler_i2c && !(i2c_stuck && reg_I2C == 8'h05)) begin
      busy_I2C = 1'b1;
      i2c_ph   = 1;
    end
  end

  always @(negedge clk_core) begin
    if (send_UART && !send_q) bytes.push_back(tx_data_UART);
    send_q = send_UART;
    if (uart_stuck) tx_busy_UART = 1'b1;
    else if (u_ph) begin
      tx_busy_UART = 1'b0;
      u_ph = 0;
    end else if (send_UART) begin
      tx_busy_UART = 1'b1;
      u_ph = 1;
    end else tx_busy_UART = 1'b0;
  end

  always @(negedge clk_core)
    if (ler_i2c && send_UART) begin
      fails++;
      $display("FAIL excl: ler_i2c and send_UART both high at %0t", $time);
    end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] frame3(input logic [7:0] a, b, c);
    return {16'h0, 8'hA0, a, 8'hA1, b, 8'hA2, c};
  endfunction

  function automatic logic [63:0] packed_bytes();
    logic [63:0] acc = '0;
    foreach (bytes[i]) acc = {acc[55:0], bytes[i]};
    return acc;
  endfunction

  task automatic run_round(input logic [7:0] a, b, c, input bit lat,
                           output int hi, output int rise);
    bit   found = 0;
    bit   pend = 0;
    logic lq;
    logic [2:0] prev;
    din_tab[0] = a;
    din_tab[1] = b;
    din_tab[2] = c;
    bytes.delete();
    hi = 0;
    rise = 0;
    prev = ch_alarm;
    for (int i = 0; i < 250 && !found; i++) begin
      @(negedge clk_core);
      if (ler_i2c) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL round_start: got no ler_i2c required one within 250");
    end
    hi = found ? 1 : 0;
    rise = hi;
    lq = ler_i2c;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk_core);
      if (ler_i2c && !lq) rise++;
      if (ler_i2c) hi++;
      lq = ler_i2c;
      if (lat) begin
        if (pend) begin
          chk("alarm_out_next", 64'(alarma_out), 64'd1);
          pend = 0;
        end
        if (prev == 3'b000 && ch_alarm != 3'b000) begin
          chk("alarm_out_same", 64'(alarma_out), 64'd0);
          pend = 1;
        end
      end
      prev = ch_alarm;
    end
  endtask

  typedef struct packed {
    logic [7:0] d0, d1, d2;
    logic [2:0] al;
    logic       out;
  } vec_t;

  vec_t tab[8];

  initial begin
    int hi, rise;
    tab[0] = '{8'd80, 8'd80,  8'd80,  3'b000, 1'b0};
    tab[1] = '{8'd80, 8'd30,  8'd80,  3'b010, 1'b1};
    tab[2] = '{8'd80, 8'd52,  8'd80,  3'b010, 1'b1};
    tab[3] = '{8'd80, 8'd60,  8'd80,  3'b000, 1'b0};
    tab[4] = '{8'd49, 8'd120, 8'd121, 3'b101, 1'b1};
    tab[5] = '{8'd50, 8'd116, 8'd115, 3'b001, 1'b1};
    tab[6] = '{8'd55, 8'd0,   8'd255, 3'b110, 1'b1};
    tab[7] = '{8'd80, 8'd80,  8'd80,  3'b000, 1'b0};

    repeat (3) @(negedge clk_core);
    chk("reset_outs", 64'({ler_i2c, send_UART, add_I2C, reg_I2C,
        tx_data_UART, alarma_out, ch_alarm, ch_err}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_round(tab[i].d0, tab[i].d1, tab[i].d2, 0, hi, rise);
      chk($sformatf("v%0d bytes", i), packed_bytes(),
          frame3(tab[i].d0, tab[i].d1, tab[i].d2));
      chk($sformatf("v%0d alarm", i), 64'(ch_alarm), 64'(tab[i].al));
      chk($sformatf("v%0d out", i), 64'(alarma_out), 64'(tab[i].out));
      chk($sformatf("v%0d err", i), 64'(ch_err), 64'd0);
    end

    // Mute, then a new alarm on another channel re-arms the buzzer.
    run_round(8'd80, 8'd30, 8'd80, 1, hi, rise);
    chk("mute_a alarm", 64'(ch_alarm), 64'b010);
    alarma = 1'b1;
    @(negedge clk_core);
    alarma = 1'b0;
    @(negedge clk_core);
    chk("muted out", 64'(alarma_out), 64'd0);
    run_round(8'd80, 8'd30, 8'd80, 0, hi, rise);
    chk("muted hold", 64'(alarma_out), 64'd0);
    run_round(8'd80, 8'd30, 8'd130, 0, hi, rise);
    chk("rearm alarm", 64'(ch_alarm), 64'b110);
    chk("rearm out", 64'(alarma_out), 64'd1);

    // I2C never acknowledges channel 0.
    i2c_stuck = 1;
    run_round(8'd80, 8'd30, 8'd130, 0, hi, rise);
    i2c_stuck = 0;
    chk("i2c_to bytes", packed_bytes(), frame3(8'hFF, 8'd30, 8'd130));
    chk("i2c_to err", 64'(ch_err), 64'b001);
    chk("i2c_to alarm", 64'(ch_alarm), 64'b110);
    chk("i2c_to ler_cycles", 64'(hi), 64'd22);
    run_round(8'd80, 8'd80, 8'd80, 0, hi, rise);
    chk("i2c_ok err", 64'(ch_err), 64'd0);
    chk("i2c_ok alarm", 64'(ch_alarm), 64'd0);

    // UART stays busy: headers go out, data bytes are abandoned.
    uart_stuck = 1;
    run_round(8'd30, 8'd80, 8'd80, 0, hi, rise);
    uart_stuck = 0;
    chk("uart_to bytes", packed_bytes(), {40'h0, 24'hA0A1A2});
    chk("uart_to ler_rise", 64'(rise), 64'd3);
    chk("uart_to alarm", 64'(ch_alarm), 64'b001);
    chk("uart_to out", 64'(alarma_out), 64'd1);
    run_round(8'd30, 8'd80, 8'd80, 0, hi, rise);
    chk("uart_ok bytes", packed_bytes(), frame3(8'd30, 8'd80, 8'd80));

    // Reset lands while the I2C read is in flight.
    begin
      bit found = 0;
      for (int i = 0; i < 250 && !found; i++) begin
        @(negedge clk_core);
        if (ler_i2c) found = 1;
      end
      chk("rst_pre start", 64'(found), 64'd1);
      chk("rst_pre addr", 64'({add_I2C, reg_I2C}), 64'h5705);
    end
    @(posedge clk_core);
    #2 reset = 1'b1;
    #1 chk("rst_mid outs", 64'({ler_i2c, send_UART, add_I2C, reg_I2C,
           tx_data_UART, alarma_out, ch_alarm, ch_err}), 64'd0);
    repeat (2) @(negedge clk_core);
    reset = 1'b0;
    bytes.delete();
    run_round(8'd80, 8'd80, 8'd80, 0, hi, rise);
    chk("post_rst bytes", packed_bytes(), frame3(8'd80, 8'd80, 8'd80));
    chk("post_rst alarm", 64'({ch_alarm, ch_err}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
